serial_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor for the ALU datapath. It processes two WIDTH-bit operands DIGIT bits per clock through a chain of full adder cells, and holds the carry between cycles in a register. A start/done handshake controls each operation. Outputs are sum, carry-out and optional signed overflow, trading latency for a small adder footprint.

---
 rtl/serial_adder_pkg.sv | 17 +
 rtl/serial_adder_if.sv | 28 ++
 rtl/serial_adder_digit_adder.sv | 45 ++++
 rtl/serial_adder.sv | 128 ++++++++++++
 tb/tb_serial_adder.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared constants for the serial adder: FSM state encodings, default geometry
// and a counter-width helper.
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DIGIT = 2;

  // A single-digit adder still needs a one-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle between an ALU sequencer (master) and serial_adder (slave).
// Handshake: start is sampled only while the adder is idle or showing done; operands
// are captured on that edge. done is a one-cycle pulse when sum/cout/overflow become
// valid, and those outputs hold until the next accepted start.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/serial_adder_digit_adder.sv
// DIGIT-wide ripple chain of full adder cells. The carry into the top bit is only
// exported when SERIAL_ADDER_OVERFLOW_EN is defined.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module digit_adder #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             msb_cin
`endif
);
  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .sum (sum[i]),
      .cout(c[i+1])
    );
  end

  assign cout = c[DIGIT];
`ifdef SERIAL_ADDER_OVERFLOW_EN
  assign msb_cin = c[DIGIT-1];
`endif
endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor processing DIGIT bits per clock with a registered carry.
// Define SERIAL_ADDER_OVERFLOW_EN to build signed-overflow tracking; otherwise overflow is 0.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIGIT = DEFAULT_DIGIT
) (
  input  logic                clk,
  input  logic                rst,
  serial_adder_if.slave       bus,
  output logic [1:0]          dbg_state
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;
  logic [WIDTH-1:0] sum_run;
  logic             last_digit;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic             dig_msb_cin;
  logic             ovf_q, ovf_d;
`endif

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a   (a_q[DIGIT-1:0]),
    .b   (b_q[DIGIT-1:0]),
    .cin (carry_q),
    .sum (dig_sum),
    .cout(dig_cout)
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    .msb_cin(dig_msb_cin)
`endif
  );

  // New digits enter at the MSB end so the result is aligned after N shifts.
  if (DIGIT == WIDTH) begin : g_sum_full
    assign sum_run = dig_sum;
  end else begin : g_sum_shift
    assign sum_run = {dig_sum, sum_q[WIDTH-1:DIGIT]};
  end

  assign last_digit = (cnt_q == CW'(N - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (bus.start) begin
          // Subtraction is A + ~B + ~borrow; cout then reads as "no borrow".
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub ? ~bus.cin : bus.cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d   = sum_run;
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = dig_cout;
        cnt_d   = cnt_q + CW'(1);
        if (last_digit) begin
          state_d = ST_DONE;
          cout_d  = dig_cout;
`ifdef SERIAL_ADDER_OVERFLOW_EN
          ovf_d   = dig_msb_cin ^ dig_cout;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

`ifdef SERIAL_ADDER_OVERFLOW_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end
  assign bus.overflow = ovf_q;
`else
  assign bus.overflow = 1'b0;
`endif

  assign bus.busy = (state_q == ST_RUN);
  assign bus.done = (state_q == ST_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8, DIGIT=2): directed table, control
// corner sequences and random operations against an arithmetic reference model.
module tb_serial_adder;
  import serial_adder_pkg::*;

  localparam int WIDTH = 8;
  localparam int DIGIT = 2;
  localparam int N     = WIDTH / DIGIT;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(WIDTH)) bus ();

  serial_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_miss = 0;
  logic [WIDTH+1:0] exp_q[$];   // {overflow, cout, sum}

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic logic [WIDTH+1:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                             input logic mc, input logic ms);
    int ua, ub, sa, sb, c, u, s;
    logic co, ov;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    c  = int'(mc);
    if (!ms) begin
      u  = ua + ub + c;
      s  = sa + sb + c;
      co = (u > 255);
    end else begin
      u  = ua - ub - c;
      s  = sa - sb - c;
      co = (ua >= ub + c);
    end
    ov = OVF_EN && ((s > 127) || (s < -128));
    return {ov, co, u[7:0]};
  endfunction

  function automatic logic [WIDTH+1:0] result();
    return {bus.overflow, bus.cout, bus.sum};
  endfunction

  // ---------------- driver ----------------
  task automatic run_op(input string nm, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic tc, input logic ts, input logic [WIDTH+1:0] exp);
    logic [WIDTH+1:0] e;
    logic busy_ok;
    @(negedge clk);
    bus.a = ta; bus.b = tb_v; bus.cin = tc; bus.sub = ts; bus.start = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = 8'($urandom); bus.b = 8'($urandom);
    bus.cin = 1'($urandom); bus.sub = 1'($urandom);
    busy_ok = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (k > 0) @(negedge clk);
      if (!(bus.busy === 1'b1 && bus.done === 1'b0)) busy_ok = 1'b0;
    end
    chk({nm, "_busy_window"}, 32'(busy_ok), 32'd1);
    @(negedge clk);
    chk({nm, "_done_busy"}, {30'd0, bus.done, bus.busy}, 32'b10);
    e = exp_q.pop_front();
    chk({nm, "_result"}, 32'(result()), 32'(e));
    @(negedge clk);
    chk({nm, "_done_pulse"}, 32'(bus.done), 32'd0);
    chk({nm, "_hold"}, 32'(result()), 32'(e));
  endtask

  // ---------------- test ----------------
  initial begin
    logic [WIDTH+1:0] e1, e2;
    logic [7:0] ra, rb;
    logic rc, rs;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
    vecs[2] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};

    rst = 1'b1;
    bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {22'd0, bus.busy, bus.done, bus.cout, bus.overflow, bus.sum}, 32'd0);
    chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 4; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
             {vecs[i].ovf & OVF_EN, vecs[i].cout, vecs[i].sum});
    end

    // start held through RUN with changing operands, then held into DONE.
    e1 = {OVF_EN, 1'b0, 8'h96};
    e2 = {1'b0, 1'b0, 8'hF0};
    @(negedge clk);
    bus.a = 8'h5A; bus.b = 8'h3C; bus.cin = 1'b0; bus.sub = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.a = 8'h10; bus.b = 8'h20; bus.sub = 1'b1;
    repeat (N - 1) @(negedge clk);
    chk("b2b_first_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("b2b_first_done", 32'(bus.done), 32'd1);
    chk("b2b_first_result", 32'(result()), 32'(e1));
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_restart", {30'd0, bus.done, bus.busy}, 32'b01);
    repeat (N - 1) @(negedge clk);
    chk("b2b_second_not_early", 32'(bus.done), 32'd0);
    @(negedge clk);
    chk("b2b_second_done", 32'(bus.done), 32'd1);
    chk("b2b_second_result", 32'(result()), 32'(e2));

    // Reset pulsed in the second RUN cycle.
    @(negedge clk);
    bus.a = 8'hFF; bus.b = 8'h01; bus.cin = 1'b1; bus.sub = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_outputs", {22'd0, bus.busy, bus.done, bus.cout, bus.overflow, bus.sum}, 32'd0);
    chk("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst", 8'h5A, 8'h3C, 1'b0, 1'b0, {OVF_EN, 1'b0, 8'h96});

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      if (i % 8 == 0) ra = 8'h80;
      if (i % 8 == 1) rb = 8'h7F;
      run_op($sformatf("rand%0d", i), ra, rb, rc, rs, model(ra, rb, rc, rs));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
